pipelined_multiplier: RTL and testbench
=======================================

PIPELINED_MULTIPLIER -- requirements
Module: pipelined_multiplier

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset; the clock port is clk and the reset port is rst.
REQ-002 clk  input  1  clock; all registers update on the rising edge.
REQ-003 rst  input  1  asynchronous reset, active low; rst=0 clears every pipeline register.
REQ-004 a  input  64  unsigned multiplicand, sampled every rising edge.
REQ-005 b  input  64  unsigned multiplier, sampled every rising edge.
REQ-006 result  output  128  unsigned product a*b, driven directly from a register.
REQ-007 The module SHALL have no parameters; all widths are fixed as listed.

Function
REQ-008 result SHALL be the full, untruncated 128-bit unsigned product of a and b; no overflow or saturation is possible.
REQ-009 The datapath SHALL be split into exactly 4 register stages:
  - S1: register a and b.
  - S2: register the four 32x32 partial products aL*bL, aL*bH, aH*bL and aH*bH (64 bits each).
  - S3: register the low term, the 65-bit sum of the cross terms, and the high term.
  - S4: register result = high<<64 + cross<<32 + low.
REQ-010 Operands sampled at rising edge k SHALL appear on result immediately after rising edge k+3 (latency 4 register stages, counting the sampling edge).
REQ-011 Throughput SHALL be one new operand pair per clock, with no stalls or bubbles.
REQ-012 Operand pairs applied on consecutive edges SHALL produce their results on consecutive edges, in order.
REQ-013 A held operand pair SHALL yield a constant result from edge k+3 onward.
REQ-014 All sums in stage S3 and stage S4 SHALL be carried at full width so that no carry is lost; for example, a=b=2^64-1 SHALL be exact.

Reset
REQ-015 While rst=0, all stage registers and result SHALL be 0, regardless of clk.
REQ-016 Reset assertion mid-operation SHALL discard all in-flight products immediately.
REQ-017 After rst is released, result SHALL stay 0 until the first operand pair sampled after release reaches stage S4, 4 edges later.
REQ-018 The first rising edge with rst=1 SHALL sample a and b normally.

Configuration
REQ-019 Macro PIPELINED_MULTIPLIER_VALID_EN, when defined, SHALL add the following ports:
  - in_valid: input, 1 bit.
  - out_valid: output, 1 bit.
REQ-020 With PIPELINED_MULTIPLIER_VALID_EN defined:
  - in_valid SHALL travel through a 4-stage shift register that is aligned with the datapath, cleared by reset, and drives out_valid.
  - result SHALL still update every cycle, independent of in_valid.
REQ-021 Without PIPELINED_MULTIPLIER_VALID_EN, the ports in_valid and out_valid SHALL NOT exist, and the behaviour is exactly as defined in REQ-008 through REQ-018.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
  - Reset: hold rst=0 for 1 cycle with a=b=0 -> result=0 throughout; release and apply a=15, b=10 -> result=150 after 4 edges.
  - Large operands: a=123456789, b=987654321 -> result=121932631112635269 after 4 edges.
  - Zero operand: a=0, b=9999 -> result=0.
  - Maximum times one: a=2^64-1, b=1 -> result=0x0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF.
  - Maximum times maximum: a=b=2^64-1 -> result=0xFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001.
  - Back-to-back pairs: apply a new pair every cycle, then assert rst mid-stream -> results appear in order on consecutive edges, result=0 immediately on assertion, and with PIPELINED_MULTIPLIER_VALID_EN defined out_valid tracks in_valid delayed by 4 edges.

Source files
------------

// File: rtl/pipelined_multiplier.sv
// rtl/pipelined_multiplier.sv - 64x64 unsigned multiplier, 4 register stages
//
// Computes the full 128-bit product of two unsigned 64-bit operands.
// The operands are split into 32-bit halves, so the datapath uses four 32x32 products.
// One operand pair is accepted every clock.
// A product appears on result after the fourth rising edge, counting the edge that samples the operands.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active low; clears every pipeline register
//   a, b       64-bit unsigned operands, sampled every rising edge
//   result     128-bit unsigned product, driven directly from the last stage register
//   in_valid   (PIPELINED_MULTIPLIER_VALID_EN only) qualifier travelling with the operands
//   out_valid  (PIPELINED_MULTIPLIER_VALID_EN only) in_valid delayed to line up with result
//
// Optional feature macro: PIPELINED_MULTIPLIER_VALID_EN adds the in_valid/out_valid
// shift register. result keeps updating every cycle whatever in_valid says.

module pipelined_multiplier (
    input  logic         clk,
    input  logic         rst,
    input  logic [63:0]  a,
    input  logic [63:0]  b,
`ifdef PIPELINED_MULTIPLIER_VALID_EN
    input  logic         in_valid,
    output logic         out_valid,
`endif
    output logic [127:0] result
);

    // S1: operand registers
    logic [63:0]  s1_a;
    logic [63:0]  s1_b;

    // S2: 32x32 partial products
    logic [63:0]  s2_ll;
    logic [63:0]  s2_lh;
    logic [63:0]  s2_hl;
    logic [63:0]  s2_hh;

    // S3: low term, combined cross terms (65 bits keeps the carry), high term
    logic [63:0]  s3_low;
    logic [64:0]  s3_cross;
    logic [63:0]  s3_high;

    // Zero-extended 32x32 partial products. Each 32-bit half is zero-extended
    // to 64 bits, so every product below is 64 bits wide and no bits are lost.
    logic [63:0]  pp_ll;
    logic [63:0]  pp_lh;
    logic [63:0]  pp_hl;
    logic [63:0]  pp_hh;

    assign pp_ll = {32'd0, s1_a[31:0]}  * {32'd0, s1_b[31:0]};
    assign pp_lh = {32'd0, s1_a[31:0]}  * {32'd0, s1_b[63:32]};
    assign pp_hl = {32'd0, s1_a[63:32]} * {32'd0, s1_b[31:0]};
    assign pp_hh = {32'd0, s1_a[63:32]} * {32'd0, s1_b[63:32]};

    // Final recombination, with every term widened to 128 bits.
    // The true product is below 2^128, so the 128-bit sum is exact.
    logic [127:0] high_term;
    logic [127:0] cross_term;
    logic [127:0] low_term;
    logic [127:0] product;

    assign high_term  = {s3_high, 64'd0};
    assign cross_term = {31'd0, s3_cross, 32'd0};
    assign low_term   = {64'd0, s3_low};
    assign product    = high_term + cross_term + low_term;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_a     <= '0;
            s1_b     <= '0;
            s2_ll    <= '0;
            s2_lh    <= '0;
            s2_hl    <= '0;
            s2_hh    <= '0;
            s3_low   <= '0;
            s3_cross <= '0;
            s3_high  <= '0;
            result   <= '0;
        end else begin
            s1_a     <= a;
            s1_b     <= b;
            s2_ll    <= pp_ll;
            s2_lh    <= pp_lh;
            s2_hl    <= pp_hl;
            s2_hh    <= pp_hh;
            s3_low   <= s2_ll;
            s3_cross <= {1'b0, s2_lh} + {1'b0, s2_hl};
            s3_high  <= s2_hh;
            result   <= product;
        end
    end

`ifdef PIPELINED_MULTIPLIER_VALID_EN
    // Bit 0 is loaded on the same edge as S1, so bit 3 lines up with result.
    logic [3:0] valid_pipe;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_pipe <= '0;
        end else begin
            valid_pipe <= {valid_pipe[2:0], in_valid};
        end
    end

    assign out_valid = valid_pipe[3];
`endif

endmodule

// File: tb/tb_pipelined_multiplier.sv
// tb/tb_pipelined_multiplier.sv - directed self-checking bench for pipelined_multiplier

module tb_pipelined_multiplier;

    logic         clk;
    logic         rst;
    logic [63:0]  a;
    logic [63:0]  b;
    logic [127:0] result;
`ifdef PIPELINED_MULTIPLIER_VALID_EN
    logic         in_valid;
    logic         out_valid;
`endif

    int n_checks;
    int n_pass;

    localparam logic [63:0] MAX64 = 64'hFFFF_FFFF_FFFF_FFFF;

    pipelined_multiplier dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
`ifdef PIPELINED_MULTIPLIER_VALID_EN
        .in_valid (in_valid),
        .out_valid(out_valid),
`endif
        .result   (result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%032h expected 0x%032h", tag, got, exp);
        end
    endtask

    // Apply a pair on a falling edge, then wait four rising edges.
    // The pair must be on result at that point, and must still be there one edge later.
    task automatic run_vec(input string tag, input logic [63:0] va, input logic [63:0] vb,
                           input logic [127:0] exp);
        @(negedge clk);
        a = va;
        b = vb;
`ifdef PIPELINED_MULTIPLIER_VALID_EN
        in_valid = 1'b1;
`endif
        repeat (4) @(negedge clk);
        check(tag, result, exp);
        @(negedge clk);
        check({tag, "_held"}, result, exp);
    endtask

    // Back-to-back stimulus with hand-computed products
    logic [63:0]  bb_a   [6];
    logic [63:0]  bb_b   [6];
    logic [127:0] bb_exp [6];
    logic         bb_vld [6];

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b0;
        a   = '0;
        b   = '0;
`ifdef PIPELINED_MULTIPLIER_VALID_EN
        in_valid = 1'b0;
`endif

        bb_a[0] = 64'd3;          bb_b[0] = 64'd5;          bb_exp[0] = 128'd15;                  bb_vld[0] = 1'b1;
        bb_a[1] = 64'd7;          bb_b[1] = 64'd11;         bb_exp[1] = 128'd77;                  bb_vld[1] = 1'b0;
        bb_a[2] = 64'd100;        bb_b[2] = 64'd200;        bb_exp[2] = 128'd20000;               bb_vld[2] = 1'b1;
        bb_a[3] = 64'h1_0000_0000; bb_b[3] = 64'h1_0000_0000; bb_exp[3] = 128'h1_0000_0000_0000_0000; bb_vld[3] = 1'b1;
        bb_a[4] = 64'hFFFF_FFFF;  bb_b[4] = 64'hFFFF_FFFF;  bb_exp[4] = 128'hFFFF_FFFE_0000_0001;  bb_vld[4] = 1'b0;
        bb_a[5] = 64'd1;          bb_b[5] = 64'd1;          bb_exp[5] = 128'd1;                   bb_vld[5] = 1'b1;

        // Reset held across a rising edge
        @(negedge clk);
        check("reset_edge", result, 128'd0);
`ifdef PIPELINED_MULTIPLIER_VALID_EN
        check("reset_valid", {127'd0, out_valid}, 128'd0);
`endif

        // Release reset and apply 15*10 for the first edge.
        // result must stay 0 for three edges and then become 150.
        rst = 1'b1;
        a   = 64'd15;
        b   = 64'd10;
`ifdef PIPELINED_MULTIPLIER_VALID_EN
        in_valid = 1'b1;
`endif
        for (int e = 1; e <= 3; e++) begin
            @(negedge clk);
            check($sformatf("post_release_e%0d", e), result, 128'd0);
        end
        @(negedge clk);
        check("first_after_release", result, 128'd150);
`ifdef PIPELINED_MULTIPLIER_VALID_EN
        check("first_valid", {127'd0, out_valid}, 128'd1);
`endif

        run_vec("large",    64'd123456789, 64'd987654321, 128'd121932631112635269);
        run_vec("zero",     64'd0,         64'd9999,      128'd0);
        run_vec("max_x1",   MAX64,         64'd1,         128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF);
        run_vec("max_xmax", MAX64,         MAX64,         128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);

        // Back-to-back pairs.
        // After the rising edge with index c, result holds pair c-3.
        for (int c = 0; c <= 6; c++) begin
            if (c < 6) begin
                a = bb_a[c];
                b = bb_b[c];
`ifdef PIPELINED_MULTIPLIER_VALID_EN
                in_valid = bb_vld[c];
`endif
            end
            @(negedge clk);
            if (c >= 3) begin
                check($sformatf("b2b_%0d", c - 3), result, bb_exp[c - 3]);
`ifdef PIPELINED_MULTIPLIER_VALID_EN
                check($sformatf("b2b_valid_%0d", c - 3), {127'd0, out_valid}, {127'd0, bb_vld[c - 3]});
`endif
            end
        end

        // Assert reset between clock edges while pairs 4 and 5 are still in flight.
        // result must clear without waiting for a clock edge.
        #2;
        rst = 1'b0;
        #1;
        check("async_reset_clear", result, 128'd0);
`ifdef PIPELINED_MULTIPLIER_VALID_EN
        check("async_reset_valid", {127'd0, out_valid}, 128'd0);
`endif
        @(negedge clk);
        check("reset_hold", result, 128'd0);

        // Release reset again; nothing that was in flight may reappear.
        rst = 1'b1;
        a   = 64'd6;
        b   = 64'd7;
        for (int e = 1; e <= 3; e++) begin
            @(negedge clk);
            check($sformatf("re_release_e%0d", e), result, 128'd0);
        end
        @(negedge clk);
        check("after_mid_reset", result, 128'd42);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
